// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: default widths, the starvation limit
// and the generic writeback request record.
package wb_pkg;
    localparam int XLEN         = 64;
    localparam int REG_AW       = 5;
    localparam int NREGS        = 1 << REG_AW;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, set at issue of a
// long-latency op and cleared when its result drains; three combinational lookup ports.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int REG_AW = wb_pkg::REG_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_idx,
    input  logic [REG_AW-1:0]      ra1,
    input  logic [REG_AW-1:0]      ra2,
    input  logic [REG_AW-1:0]      ra3,
    output logic                   hit1,
    output logic                   hit2,
    output logic                   hit3,
    output logic [(1<<REG_AW)-1:0] pending
);
    localparam int NREGS = 1 << REG_AW;

    logic [NREGS-1:0] pending_nxt;

    // Clear is applied first so a same-cycle set of the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        if (set_en) pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    always_comb begin
        hit1 = (ra1 != '0) && pending[ra1];
        hit2 = (ra2 != '0) && pending[ra2];
        hit3 = (ra3 != '0) && pending[ra3];
    end
endmodule

// File: rtl/wb_writeback_arbiter.sv
// WB-stage register file writer: merges the in-order ALU stream with long-latency results
// held in a 1-entry buffer, with a starvation guard and a pending-destination scoreboard.
module wb_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = wb_pkg::XLEN,
    parameter int REG_AW       = wb_pkg::REG_AW,
    parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_stall,
    input  logic              ll_issue,
    input  logic [REG_AW-1:0] ll_issue_rd,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [REG_AW-1:0] ll_rd,
    input  logic [XLEN-1:0]   ll_data,
    input  logic [REG_AW-1:0] chk_ra1,
    input  logic [REG_AW-1:0] chk_ra2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              sb_stall,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data
);
    localparam int NREGS = 1 << REG_AW;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic              hold_valid;
    logic [REG_AW-1:0] hold_rd;
    logic [XLEN-1:0]   hold_data;
    logic [CNT_W-1:0]  starve_cnt;

    logic alu_wr, force_hold, sel_alu, drain, accept;
    logic hit1, hit2, hit3;
    logic [NREGS-1:0] pending;

    // Selection stage: decide which source owns the single write slot this cycle.
    always_comb begin
        alu_wr     = alu_valid && (alu_rd != '0);
        force_hold = hold_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
        drain      = hold_valid && (force_hold || !alu_wr);
        sel_alu    = alu_wr && !force_hold;
        ll_ready   = !rst && (!hold_valid || drain);
        accept     = ll_valid && ll_ready;
        alu_stall  = !rst && force_hold && alu_wr;
        sb_stall   = hit1 || hit2 || hit3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid   <= 1'b0;
            starve_cnt   <= '0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            hold_valid <= accept || (hold_valid && !drain);
            if (drain)
                starve_cnt <= '0;
            else if (sel_alu && hold_valid && starve_cnt != CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CNT_W'(1);
            // Output stage: a drained x0 result occupies the slot but never writes.
            wb_reg_write <= sel_alu || (drain && hold_rd != '0);
            if (sel_alu) begin
                wb_rd   <= alu_rd;
                wb_data <= alu_data;
            end else if (drain && hold_rd != '0) begin
                wb_rd   <= hold_rd;
                wb_data <= hold_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_rd   <= ll_rd;
            hold_data <= ll_data;
        end
    end

    wb_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (ll_issue && (ll_issue_rd != '0)),
        .set_idx (ll_issue_rd),
        .clr_en  (drain),
        .clr_idx (hold_rd),
        .ra1     (chk_ra1),
        .ra2     (chk_ra2),
        .ra3     (chk_rd),
        .hit1    (hit1),
        .hit2    (hit2),
        .hit3    (hit3),
        .pending (pending)
    );

    // ID stalls on pending destinations, so an ALU write to one indicates a pipeline bug.
    always @(posedge clk) begin
        if (!rst && alu_wr) assert (!pending[alu_rd]);
    end
endmodule
